ard00_ref_seq: RTL



---
 rtl/ard00_ref_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ard00_ref_seq.sv
// Power-up sequencer and trim controller for the ARD00 bandgap/reference macro.
// Owns macro enable, slew-limited bandgap trim, test enables and refok supervision.
module ard00_ref_seq #(
  parameter int unsigned SETTLE_CYC   = 64,
  parameter int unsigned OK_DEBOUNCE  = 8,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter logic [6:0]  TRIM_DEFAULT = 7'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] trim_in,
  input  logic       trim_ld,
  input  logic [1:0] test_mode,
  input  logic       refok,
  output logic       en,
  output logic [6:0] trimBG,
  output logic       ten_bg,
  output logic       ten_ref,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned CMAX = (SETTLE_CYC > OK_DEBOUNCE) ? SETTLE_CYC : OK_DEBOUNCE;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_SETTLE  = 3'd1,
    S_WAIT_OK = 3'd2,
    S_READY   = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [6:0]    tgt_q, tgt_d;
  logic [6:0]    trim_q, trim_d;
  logic [1:0]    sync_q;
  logic          refok_s;
  logic          en_q, en_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          ten_bg_q, ten_bg_d;
  logic          ten_ref_q, ten_ref_d;

  assign refok_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= S_OFF;
      cnt_q     <= '0;
      tmo_q     <= '0;
      tgt_q     <= TRIM_DEFAULT;
      trim_q    <= TRIM_DEFAULT;
      en_q      <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      ten_bg_q  <= 1'b0;
      ten_ref_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], refok};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      tgt_q     <= tgt_d;
      trim_q    <= trim_d;
      en_q      <= en_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      ten_bg_q  <= ten_bg_d;
      ten_ref_q <= ten_ref_d;
    end
  end

  // cnt_q is shared: settle count, then high-debounce in WAIT_OK, then low-debounce in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    if (!start) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
        S_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_d = S_WAIT_OK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT_OK: begin
          tmo_d = tmo_q + TW'(1);
          cnt_d = refok_s ? cnt_q + CW'(1) : '0;
          if (refok_s && cnt_q == CW'(OK_DEBOUNCE - 1)) begin
            state_d = S_READY;
            cnt_d   = '0;
            tmo_d   = '0;
          end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = S_FAULT;
            cnt_d   = '0;
            tmo_d   = '0;
          end
        end
        S_READY: begin
          cnt_d = refok_s ? '0 : cnt_q + CW'(1);
          if (!refok_s && cnt_q == CW'(OK_DEBOUNCE - 1)) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Target bypass lets trim react on the same edge that captures trim_ld.
  always_comb begin
    tgt_d  = trim_ld ? trim_in : tgt_q;
    trim_d = trim_q;
    if (state_q == S_OFF) begin
      trim_d = tgt_d;
    end else if (!start) begin
      trim_d = trim_q;
    end else if (trim_q < tgt_d) begin
      trim_d = trim_q + 7'd1;
    end else if (trim_q > tgt_d) begin
      trim_d = trim_q - 7'd1;
    end
  end

  always_comb begin
    en_d      = (state_d != S_OFF);
    ready_d   = (state_d == S_READY);
    fault_d   = (state_d == S_FAULT);
    ten_bg_d  = (state_d == S_READY) && test_mode[0];
    ten_ref_d = (state_d == S_READY) && test_mode[1];
  end

  assign en      = en_q;
  assign trimBG  = trim_q;
  assign ten_bg  = ten_bg_q;
  assign ten_ref = ten_ref_q;
  assign ready   = ready_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule
